dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 20 ++
 rtl/dmem_arbiter.sv | 98 +++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester handshake and data-memory port of dmem_arbiter.
// slave is the arbiter's view; master is the requesters/memory side.
interface dmem_arbiter_if #(
  parameter int DW = 32
);
  logic [1:0] i_req, i_we;
  logic [DW-1:0] i_addr0, i_addr1, i_wdata0, i_wdata1;
  logic [1:0] o_gnt, o_done, o_err;
  logic [DW-1:0] o_rdata;
  logic o_mem_we;
  logic [DW-1:0] o_mem_addr, o_mem_wdata, i_mem_rdata;
  modport slave (
    input i_req, i_we, i_addr0, i_addr1, i_wdata0, i_wdata1, i_mem_rdata,
    output o_gnt, o_done, o_err, o_rdata, o_mem_we, o_mem_addr, o_mem_wdata
  );
  modport master (
    output i_req, i_we, i_addr0, i_addr1, i_wdata0, i_wdata1, i_mem_rdata,
    input o_gnt, o_done, o_err, o_rdata, o_mem_we, o_mem_addr, o_mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port data-memory arbiter, one access per IDLE/ISSUE/WAIT pass, all outputs registered.
// Define DMEM_ARB_RR_EN for round-robin; otherwise port 0 has fixed priority.
module dmem_arbiter #(
  parameter int ADDR_LIMIT = 256,
  parameter int DW = 32
) (
  input logic i_clk,
  input logic i_rst,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state, state_d;
  logic win, win_d, bad, bad_d, rd, rd_d;
  logic pick, sel_we, sel_bad, mem_we_d;
  logic [1:0] gnt_d, done_d, err_d;
  logic [DW-1:0] sel_addr, sel_wdata, rdata_d, addr_d, wdata_d;
`ifdef DMEM_ARB_RR_EN
  logic ptr, ptr_d;
  assign pick = &bus.i_req ? ~ptr : bus.i_req[1];
`else
  assign pick = ~bus.i_req[0];
`endif
  assign sel_we = bus.i_we[pick];
  assign sel_addr = pick ? bus.i_addr1 : bus.i_addr0;
  assign sel_wdata = pick ? bus.i_wdata1 : bus.i_wdata0;
  assign sel_bad = (sel_addr >= DW'(ADDR_LIMIT)) || (|sel_addr[1:0]);
  always_comb begin
    state_d = state;
    win_d = win;
    bad_d = bad;
    rd_d = rd;
    gnt_d = '0;
    done_d = '0;
    mem_we_d = 1'b0;
    err_d = bus.o_err;
    rdata_d = bus.o_rdata;
    addr_d = bus.o_mem_addr;
    wdata_d = bus.o_mem_wdata;
`ifdef DMEM_ARB_RR_EN
    ptr_d = ptr;
`endif
    case (state)
      IDLE: if (|bus.i_req) begin
        state_d = ISSUE;
        win_d = pick;
        bad_d = sel_bad;
        rd_d = ~sel_we & ~sel_bad;
        gnt_d = {pick, ~pick};
        mem_we_d = sel_we & ~sel_bad;
        addr_d = sel_addr;
        wdata_d = sel_wdata;
`ifdef DMEM_ARB_RR_EN
        ptr_d = pick;
`endif
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        state_d = IDLE;
        done_d = {win, ~win};
        err_d = {win & bad, ~win & bad};
        rdata_d = rd ? bus.i_mem_rdata : '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state <= IDLE;
      win <= 1'b0;
      bad <= 1'b0;
      rd <= 1'b0;
      bus.o_gnt <= '0;
      bus.o_done <= '0;
      bus.o_err <= '0;
      bus.o_rdata <= '0;
      bus.o_mem_we <= 1'b0;
      bus.o_mem_addr <= '0;
      bus.o_mem_wdata <= '0;
    end else begin
      state <= state_d;
      win <= win_d;
      bad <= bad_d;
      rd <= rd_d;
      bus.o_gnt <= gnt_d;
      bus.o_done <= done_d;
      bus.o_err <= err_d;
      bus.o_rdata <= rdata_d;
      bus.o_mem_we <= mem_we_d;
      bus.o_mem_addr <= addr_d;
      bus.o_mem_wdata <= wdata_d;
    end
`ifdef DMEM_ARB_RR_EN
  // pointer remembers the last winner so a tie goes to the other port
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) ptr <= 1'b1;
    else ptr <= ptr_d;
`endif
endmodule
